// File: rtl/ram_sweep.sv
// ram_sweep: RAM fill/dump/verify engine that sweeps a wrapping address range with an incrementing pattern.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, mode           operation request (00 FILL, 01 DUMP, 10 VERIFY, 11 no-op), taken only when idle
//   base_addr, length     first address and word count (0..DEPTH); addresses wrap at DEPTH
//   seed                  word i of a sweep is compared/written as seed+i
//   busy, done            operation in progress / one-cycle completion pulse
//   out_data, out_valid,
//   out_ready             DUMP read stream with valid/ready handshake
//   err_count,
//   first_err_addr,
//   first_err_valid       VERIFY results
module ram_sweep #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  first_err_valid
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, FILL, SCAN, FLUSH, FINISH} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q, idx, rd_idx;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  rd_pend, accept, verify, last, consume, issue, we, mismatch;
    logic [ADDR_WIDTH-1:0] addr;

    always_comb begin
        accept    = state == IDLE && start;
        verify    = mode_q == 2'b10;
        last      = idx == len_q - 1'b1;
        // out_data doubles as the registered read port; a pending word leaves when taken (VERIFY always takes it)
        consume   = rd_pend && (verify || out_ready);
        issue     = state == SCAN && (!rd_pend || consume);
        we        = state == FILL && !reset;
        addr      = base_q + idx[ADDR_WIDTH-1:0];
        mismatch  = consume && verify && out_data != seed_q + DATA_WIDTH'(rd_idx);
        busy      = state != IDLE;
        done      = state == FINISH;
        out_valid = rd_pend && mode_q == 2'b01;
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (mode == 2'b11 || length == '0) ? FINISH
                                           : (mode == 2'b00) ? FILL : SCAN;
            FILL:    state_next = last ? FINISH : FILL;
            SCAN:    state_next = (issue && last) ? FLUSH : SCAN;
            FLUSH:   state_next = consume ? FINISH : FLUSH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= seed_q + DATA_WIDTH'(idx);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q          <= '0;
            base_q          <= '0;
            len_q           <= '0;
            seed_q          <= '0;
            idx             <= '0;
            rd_idx          <= '0;
            rd_pend         <= 1'b0;
            out_data        <= '0;
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
        end else begin
            if (accept) begin
                mode_q <= mode;
                base_q <= base_addr;
                len_q  <= length;
                seed_q <= seed;
                idx    <= '0;
                rd_idx <= '0;
                if (mode == 2'b10) begin
                    err_count       <= '0;
                    first_err_addr  <= '0;
                    first_err_valid <= 1'b0;
                end
            end
            if (state == FILL || issue) idx <= idx + 1'b1;
            if (issue) out_data <= mem[addr];
            rd_pend <= issue || (rd_pend && !consume);
            if (consume) rd_idx <= rd_idx + 1'b1;
            if (mismatch) begin
                err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
                if (!first_err_valid) begin
                    first_err_addr  <= base_q + rd_idx[ADDR_WIDTH-1:0];
                    first_err_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_sweep.sv
// tb_ram_sweep: randomized self-checking bench for ram_sweep against an array-based memory model.
module tb_ram_sweep;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] seed = '0;
    logic          out_ready = 1'b0;
    logic          busy, done, out_valid, first_err_valid;
    logic [DW-1:0] out_data;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] model [DEPTH];
    int            m_err = 0;
    int            m_faddr = 0;
    int            m_fvalid = 0;

    ram_sweep #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed),
        .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_valid(first_err_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = stall 3 cycles while word 1 is presented
    task automatic run_op(input int m, input int b, input int len, input logic [DW-1:0] s, input int ready_mode);
        int cyc = 0, got_words = 0, stall_n = 0, exp_cyc, e_err = 0, e_faddr = 0, e_fvalid = 0;
        bit busy_bad = 0, valid_bad = 0, word_bad = 0, stab_bad = 0, stalled = 0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] exp_w;
        start = 1'b1;
        mode = 2'(m);
        base_addr = AW'(b);
        length = (AW+1)'(len);
        seed = s;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        mode = 2'($urandom);
        base_addr = AW'($urandom);
        length = (AW+1)'($urandom);
        seed = $urandom;
        while (!done && cyc < 2000) begin
            if (!busy) busy_bad = 1;
            start = 1'($urandom_range(0, 1));
            out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1))
                      : !(out_valid && got_words == 1 && stall_n < 3);
            if (ready_mode == 2 && !out_ready) stall_n++;
            if (m == 1) begin
                if (stalled && (!out_valid || out_data !== held)) stab_bad = 1;
                stalled = 0;
                if (out_valid) begin
                    if (out_ready) begin
                        exp_w = model[(b + got_words) % DEPTH];
                        if (got_words >= len || out_data !== exp_w) word_bad = 1;
                        got_words++;
                    end else begin
                        held = out_data;
                        stalled = 1;
                    end
                end
            end else if (out_valid) valid_bad = 1;
            step();
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("busy_in_finish", busy, 1);
        check("busy_during_op", busy_bad, 0);
        exp_cyc = (m == 3 || len == 0) ? 0 : (m == 0 ? len : len + 1);
        if (ready_mode == 0 || m != 1) check("latency", cyc, exp_cyc);
        if (m == 1 && len > 0) begin
            check("dump_words", got_words, len);
            check("dump_data", word_bad, 0);
            check("dump_stable", stab_bad, 0);
        end
        if (m != 1) check("out_valid_low", valid_bad, 0);
        if (m == 0)
            for (int i = 0; i < len; i++) model[(b + i) % DEPTH] = s + DW'(i);
        if (m == 2) begin
            for (int i = 0; i < len; i++)
                if (model[(b + i) % DEPTH] !== s + DW'(i)) begin
                    if (!e_fvalid) begin
                        e_fvalid = 1;
                        e_faddr = (b + i) % DEPTH;
                    end
                    if (e_err < 65535) e_err++;
                end
            m_err = e_err;
            m_faddr = e_faddr;
            m_fvalid = e_fvalid;
        end
        step();
        check("done_pulse_end", done, 0);
        check("idle_after", busy, 0);
        check("err_count", err_count, m_err);
        check("first_err_valid", first_err_valid, m_fvalid);
        check("first_err_addr", first_err_addr, m_faddr);
    endtask

    initial begin
        int b, len, s;
        bit saw_done;
        repeat (3) step();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_err_addr", first_err_addr, 0);
        check("rst_first_err_valid", first_err_valid, 0);

        run_op(0, 0, DEPTH, $urandom, 0);
        run_op(1, 0, DEPTH, 0, 1);

        run_op(0, 'h10, 4, 32'hAFFE1234, 0);
        run_op(1, 'h10, 4, 32'hAFFE1234, 0);

        run_op(0, 'hFE, 4, 0, 0);
        check("wrap_ff", model[255], 1);
        run_op(1, 0, 2, 0, 0);
        run_op(1, 'hFE, 4, 0, 1);

        run_op(1, 'h10, 4, 0, 2);

        run_op(0, 0, 8, 0, 0);
        run_op(0, 3, 1, 32'h100, 0);
        run_op(2, 0, 8, 0, 1);
        check("verify_err_is_1", err_count, 1);
        check("verify_addr_is_3", first_err_addr, 3);
        run_op(1, 0, 8, 0, 0);

        run_op(0, 5, 0, 32'hDEAD, 0);
        run_op(3, 0, 8, 32'h55, 0);
        run_op(1, 0, 8, 0, 0);

        start = 1'b1;
        mode = 2'b00;
        base_addr = '0;
        length = 9'd8;
        seed = 32'h1234_0000;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err_count", err_count, 0);
        m_err = 0;
        m_faddr = 0;
        m_fvalid = 0;
        saw_done = 0;
        repeat (10) begin
            step();
            if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        model[0] = 32'h1234_0000;
        model[1] = 32'h1234_0001;
        run_op(1, 0, 8, 0, 1);

        for (int k = 0; k < 24; k++) begin
            b = $urandom_range(0, DEPTH - 1);
            len = $urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH) : $urandom_range(0, 12);
            s = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    run_op(0, b, len, s, 1);
                    run_op(2, b, len, s, 1);
                end
                1: run_op(1, b, len, s, $urandom_range(0, 1));
                2: run_op(2, b, len, model[b], 1);
                default: run_op(3, b, len, s, 1);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_sweep.md
RAM_SWEEP -- requirements
Module: ram_sweep

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of internal RAM and of pattern data.
REQ-002 Parameter ADDR_WIDTH, default 8, RAM address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request an operation; sampled only in IDLE.
REQ-006 mode  in  2  operation: 00 FILL, 01 DUMP, 10 VERIFY, 11 reserved.
REQ-007 base_addr  in  ADDR_WIDTH  first RAM address of the sweep.
REQ-008 length  in  ADDR_WIDTH+1  number of words, 0..DEPTH.
REQ-009 seed  in  DATA_WIDTH  pattern base; word i of a sweep has pattern seed+i.
REQ-010 busy  out  1  operation in progress.
REQ-011 done  out  1  one-cycle pulse at operation end.
REQ-012 out_data  out  DATA_WIDTH  DUMP read data.
REQ-013 out_valid  out  1  out_data valid (DUMP only).
REQ-014 out_ready  in  1  downstream accepts out_data when out_valid and out_ready are both 1.
REQ-015 err_count  out  16  VERIFY mismatch count.
REQ-016 first_err_addr  out  ADDR_WIDTH  address of first VERIFY mismatch.
REQ-017 first_err_valid  out  1  first_err_addr holds a captured mismatch.

Function
REQ-018 Internal RAM SHALL be DEPTH x DATA_WIDTH, one write port, one registered read port with 1-cycle read latency.
REQ-019 FSM states SHALL be IDLE, FILL, SCAN, FLUSH, FINISH.
REQ-020 Transition IDLE->FILL SHALL occur on start=1 with mode=00; IDLE->SCAN on start=1 with mode 01 or 10; IDLE->FINISH on start=1 with mode=11 or length=0.
REQ-021 On accepting start, the block SHALL latch mode, base_addr, length and seed; later input changes SHALL NOT affect the running operation.
REQ-022 busy SHALL be 1 from the cycle after start is accepted through the FINISH cycle inclusive.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 Sweep address i SHALL be (base_addr+i) mod DEPTH, so sweeps wrap from DEPTH-1 to 0.
REQ-025 Pattern i SHALL be (seed+i) mod 2**DATA_WIDTH.
REQ-026 FILL SHALL write one word per cycle, for exactly length consecutive cycles, then go to FINISH.
REQ-027 SCAN SHALL issue one read per cycle while the output stage can accept data; after the last read it SHALL go to FLUSH and wait for the final word, then go to FINISH.
REQ-028 DUMP: out_valid=1 with out_data = word i in order i=0..length-1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 DUMP: no word SHALL be dropped or duplicated under any out_ready pattern; with out_ready held at 1, throughput SHALL be 1 word per cycle.
REQ-030 VERIFY: out_valid SHALL stay 0 and out_ready SHALL be ignored; each read word SHALL be compared with pattern i.
REQ-031 err_count SHALL clear to 0 when VERIFY is accepted, increment by 1 per mismatch, saturate at 0xFFFF, and hold its value after done.
REQ-032 first_err_valid and first_err_addr SHALL clear when VERIFY is accepted; on the first mismatch the block SHALL capture its address and set first_err_valid.
REQ-033 FINISH SHALL last one cycle and assert done=1, then return to IDLE.
REQ-034 RAM writes SHALL occur only in FILL.

Reset
REQ-035 reset=1 SHALL force IDLE on the next edge and drive busy, done, out_valid, first_err_valid to 0 and err_count, first_err_addr, out_data to 0.
REQ-036 Reset mid-operation SHALL abort the sweep; no further RAM writes SHALL occur and no done pulse SHALL be produced.
REQ-037 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-038 FILL base 0x10, len 4, seed 0xAFFE1234, then DUMP (same base, len, seed) with out_ready=1 -> out_data 0xAFFE1234, 0xAFFE1235, 0xAFFE1236, 0xAFFE1237 on consecutive cycles, followed by one done pulse.
REQ-039 FILL base 0xFE, len 4, seed 0 -> writes land at 0xFE, 0xFF, 0x00, 0x01 with data 0..3; DUMP base 0x00 len 2 -> 2, 3.
REQ-040 DUMP len 4 with out_ready=0 for 3 cycles while word 1 is presented -> word 1 held stable throughout, all 4 words delivered in order, none lost or duplicated.
REQ-041 FILL base 0 len 8 seed 0; FILL base 3 len 1 seed 0x100; VERIFY base 0 len 8 seed 0 -> err_count=1, first_err_addr=3, first_err_valid=1, out_valid=0 throughout.
REQ-042 start with len=0 -> done pulse 1 cycle later, no RAM write; mode=11 -> done pulse, RAM unchanged.
REQ-043 Reset at write 2 of a FILL len 8 -> busy=0 after the next edge, addresses 2..7 keep their prior contents, no done pulse; start pulsed during busy -> ignored.
